siren_driver: RTL
=================

# siren_driver

Output-side counterpart to the input debouncer in the anti-theft design. It takes the clean, level-type alarm command from the alarm controller FSM and drives the physical siren pin with a timed on/off pulse pattern. It enforces a maximum sounding duration per trigger, then holds a lockout until the command is released.

## Interface
- `CLK_DIV`, 500_000: clock cycles per timing tick; must be ≥ 2.
- `ON_TICKS`, 2: ticks per siren-on phase; must be ≥ 1.
- `OFF_TICKS`, 2: ticks per siren-off phase; must be ≥ 1.
- `MAX_TICKS`, 20: maximum ticks per trigger before forced silence; must be ≥ 1.

- `clock_in` in 1: single system clock; all logic is on its rising edge.
- `reset_in` in 1: synchronous, active-high reset.
- `siren_en_in` in 1: clean level command; 1 requests alarm sounding.
- `siren_out` out 1: registered siren drive, 1 = sounding.
- `busy_out` out 1: registered; 1 while in ON or OFF.
- `lockout_out` out 1: registered; 1 while in LOCKOUT.

## Operation
- States are IDLE, ON, OFF and LOCKOUT.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - `siren_out` = (state == ON).
  - `busy_out` = (state ∈ {ON, OFF}).
  - `lockout_out` = (state == LOCKOUT).
- Counters:
  - `presc`: range 0..CLK_DIV-1, width $clog2(CLK_DIV).
  - `phase_cnt`: range 0..max(ON_TICKS, OFF_TICKS)-1.
  - `total_cnt`: range 0..MAX_TICKS-1.
  - No counter ever wraps past its maximum.
- Tick generation, in ON/OFF at each edge:
  - If `presc` == CLK_DIV-1, a tick occurs and `presc` ← 0.
  - Otherwise `presc` ← `presc`+1.
- Transitions are evaluated in priority order at each edge:
  1. `reset_in`=1 → IDLE; all counters 0; all outputs 0.
  2. In ON or OFF with `siren_en_in`=0 → IDLE. Counters are don't-care.
  3. In IDLE with `siren_en_in`=1 → ON; `presc`, `phase_cnt` and `total_cnt` ← 0.
  4. In ON/OFF, a tick with `total_cnt` == MAX_TICKS-1 → LOCKOUT. This takes priority over the phase change.
  5. In ON, a tick with `phase_cnt` == ON_TICKS-1 → OFF; `phase_cnt` ← 0; `total_cnt`+1.
  6. In OFF, a tick with `phase_cnt` == OFF_TICKS-1 → ON; `phase_cnt` ← 0; `total_cnt`+1.
  7. Any other tick: `phase_cnt`+1 and `total_cnt`+1.
  8. In LOCKOUT with `siren_en_in`=0 → IDLE. While `siren_en_in` stays 1, the block remains in LOCKOUT: there is no retrigger without release.
- Boundary cases:
  - `siren_en_in` high during reset: IDLE is held while reset is asserted. ON is entered on the first edge with `reset_in`=0.
  - One-cycle `siren_en_in` pulse in IDLE: the block enters ON, then returns to IDLE on the next edge. `siren_out` is high for exactly 1 cycle.
  - MAX_TICKS ≤ ON_TICKS: the first ON phase is truncated and LOCKOUT follows directly.

## Timing
- Let k be the edge at which IDLE samples `siren_en_in`=1. `siren_out` is 1 from edge k onward, so rise latency is 1 cycle.
- Each ON phase lasts exactly ON_TICKS×CLK_DIV cycles, and each OFF phase exactly OFF_TICKS×CLK_DIV cycles.
- The first tick occurs at edge k+CLK_DIV.
- LOCKOUT is entered at edge k+MAX_TICKS×CLK_DIV when enable is held throughout.
- Release of `siren_en_in` forces `siren_out`/`busy_out` to 0 at the next edge, so fall latency is 1 cycle.
- LOCKOUT exits at the edge after `siren_en_in` is sampled 0. Re-entry to ON then needs `siren_en_in`=1 sampled in IDLE, at least one further edge later.

## Test plan
All scenarios use CLK_DIV=4, ON_TICKS=2, OFF_TICKS=2, MAX_TICKS=10 unless stated.
- **Reset:** hold `reset_in`=1 for 3 cycles with `siren_en_in`=1 → all outputs 0 during reset. `siren_out`=1 one edge after `reset_in` drops.
- **Pattern and lockout:** raise `siren_en_in` at edge k and hold it → `siren_out` high for edges k..k+7, low for k+8..k+15, high for k+16..k+23, and so on. At edge k+40, `siren_out`=0 and `lockout_out`=1, held for 50 further cycles.
- **Lockout release:** from LOCKOUT, drop `siren_en_in` for 1 cycle, then raise it → `lockout_out`=0 and state IDLE after the drop. `siren_out`=1 one edge after the re-raise, and the full 8/8 pattern restarts.
- **Mid-phase release:** drop `siren_en_in` at edge k+5 (mid-ON) → `siren_out` and `busy_out` = 0 at edge k+6. Re-raise at k+10 → a fresh ON phase lasts 8 cycles.
- **Mid-operation reset:** assert `reset_in` at edge k+12 (mid-OFF), then release → all outputs 0 during reset. The pattern restarts from a fresh ON, with `total_cnt` cleared so a full 40-cycle burst follows.
- **Short pulse and truncation:** a 1-cycle `siren_en_in` pulse gives a 1-cycle `siren_out`. Separately, with MAX_TICKS=1, held enable → `siren_out` high for 4 cycles, then LOCKOUT.

Source files
------------

// File: rtl/siren_driver_if.sv
// Alarm-command / siren-status bundle between the alarm controller (master) and the siren driver (slave).
// Plain level signals: no handshake, the driver consumes the command every cycle.
interface siren_driver_if;
  logic siren_en_in;
  logic siren_out;
  logic busy_out;
  logic lockout_out;

  modport master (
    output siren_en_in,
    input  siren_out,
    input  busy_out,
    input  lockout_out
  );

  modport slave (
    input  siren_en_in,
    output siren_out,
    output busy_out,
    output lockout_out
  );
endinterface

// File: rtl/siren_driver.sv
// Drives the siren pin with an on/off pattern of CLK_DIV-cycle ticks, capped at MAX_TICKS per trigger, then locks out until release.
// Outputs are registered from the next state (1-cycle rise/fall latency); no backpressure, the command is sampled every cycle.
module siren_driver #(
  parameter int CLK_DIV   = 500_000,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int MAX_TICKS = 20
) (
  input  logic          clock_in,
  input  logic          reset_in,
  siren_driver_if.slave bus
);

  localparam int PHASE_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PRESC_W   = $clog2(CLK_DIV);
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int TOTAL_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [PHASE_W-1:0] ON_LAST    = PHASE_W'(ON_TICKS - 1);
  localparam logic [PHASE_W-1:0] OFF_LAST   = PHASE_W'(OFF_TICKS - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
  localparam logic [TOTAL_W-1:0] TOTAL_LAST = TOTAL_W'(MAX_TICKS - 1);
  localparam logic [TOTAL_W-1:0] TOTAL_ONE  = TOTAL_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ON      = 2'd1,
    OFF     = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [PRESC_W-1:0] presc_q, presc_nxt;
  logic [PHASE_W-1:0] phase_q, phase_nxt;
  logic [TOTAL_W-1:0] total_q, total_nxt;
  logic               siren_q, busy_q, lockout_q;
  logic               tick;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      phase_q   <= '0;
      total_q   <= '0;
      siren_q   <= 1'b0;
      busy_q    <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      presc_q   <= presc_nxt;
      phase_q   <= phase_nxt;
      total_q   <= total_nxt;
      siren_q   <= (state_nxt == ON);
      busy_q    <= (state_nxt == ON) || (state_nxt == OFF);
      lockout_q <= (state_nxt == LOCKOUT);
    end
  end

  always_comb begin
    state_nxt = state_q;
    presc_nxt = presc_q;
    phase_nxt = phase_q;
    total_nxt = total_q;
    tick      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.siren_en_in) begin
          state_nxt = ON;
          presc_nxt = '0;
          phase_nxt = '0;
          total_nxt = '0;
        end
      end

      ON, OFF: begin
        tick = (presc_q == PRESC_LAST);
        if (!bus.siren_en_in) begin
          state_nxt = IDLE;
        end else begin
          presc_nxt = tick ? '0 : presc_q + PRESC_ONE;
          if (tick) begin
            // The duration cap wins over a phase boundary on the same tick.
            if (total_q == TOTAL_LAST) begin
              state_nxt = LOCKOUT;
            end else if (state_q == ON && phase_q == ON_LAST) begin
              state_nxt = OFF;
              phase_nxt = '0;
              total_nxt = total_q + TOTAL_ONE;
            end else if (state_q == OFF && phase_q == OFF_LAST) begin
              state_nxt = ON;
              phase_nxt = '0;
              total_nxt = total_q + TOTAL_ONE;
            end else begin
              phase_nxt = phase_q + PHASE_ONE;
              total_nxt = total_q + TOTAL_ONE;
            end
          end
        end
      end

      LOCKOUT: begin
        if (!bus.siren_en_in) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.siren_out   = siren_q;
  assign bus.busy_out    = busy_q;
  assign bus.lockout_out = lockout_q;

endmodule
